// File: rtl/core_dispatch_queue_pkg.sv
// Shared types and helpers for the decode-to-dispatch queue.
package core_dispatch_queue_pkg;

    localparam int dispatch_queue_depth = 8;

    typedef logic [3:0]  reg_num;
    typedef logic [15:0] hword;

    typedef struct packed {
        logic execute;
        logic uses_ra;
        logic uses_rb;
        logic writes_rd;
    } insn_ctrl;

    typedef struct packed {
        reg_num     ra;
        reg_num     rb;
        reg_num     rd;
        logic [15:0] imm;
    } insn_data;

    typedef struct packed {
        insn_ctrl ctrl;
        insn_data data;
    } insn_decode;

    // One-hot register mask; zero when the operand is unused.
    function automatic hword reg_onehot(reg_num r, logic use_flag);
        hword m;
        m = '0;
        if (use_flag) m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/core_dispatch_queue_mask.sv
// Turns one queued instruction into its source-register one-hot masks.
module core_dispatch_queue_mask
    import core_dispatch_queue_pkg::*;
(
    input  insn_decode i_insn,
    output hword       o_mask_ra,
    output hword       o_mask_rb
);

    assign o_mask_ra = reg_onehot(i_insn.data.ra, i_insn.ctrl.uses_ra);
    assign o_mask_rb = reg_onehot(i_insn.data.rb, i_insn.ctrl.uses_rb);

endmodule

// File: rtl/core_dispatch_queue.sv
// Two-in / two-out circular FIFO between decode and the dispatch hazard check.
// Validity of each slot comes only from the occupancy count; storage is never cleared.
module core_dispatch_queue
    import core_dispatch_queue_pkg::*;
#(
    parameter int DEPTH = dispatch_queue_depth
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_flush,
    input  logic                     i_in_valid_a,
    input  logic                     i_in_valid_b,
    input  insn_decode               i_in_a,
    input  insn_decode               i_in_b,
    output logic                     o_in_ready,
    input  logic                     i_dispatch_a,
    input  logic                     i_dispatch_b,
    output insn_decode               o_cur_a,
    output insn_decode               o_cur_b,
    output hword                     o_mask_a_ra,
    output hword                     o_mask_a_rb,
    output hword                     o_mask_b_ra,
    output hword                     o_mask_b_rb,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    insn_decode      r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic [1:0]      w_n_push;
    logic [1:0]      w_n_pop;
    logic [PW-1:0]   w_head_p1;
    logic [PW-1:0]   w_tail_p1;

    // Ready depends on registered occupancy only, so same-cycle pops never open the gate.
    assign o_in_ready = (r_count <= CW'(DEPTH - 2));
    assign w_push     = o_in_ready && i_in_valid_a;
    assign w_n_push   = w_push ? (i_in_valid_b ? 2'd2 : 2'd1) : 2'd0;
    // dispatch_b alone pops nothing.
    assign w_n_pop    = {i_dispatch_a & i_dispatch_b, i_dispatch_a & ~i_dispatch_b};
    assign w_head_p1  = r_head + PW'(1);
    assign w_tail_p1  = r_tail + PW'(1);

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_pop);
            r_tail  <= r_tail + PW'(w_n_push);
            r_count <= r_count + CW'(w_n_push) - CW'(w_n_pop);
        end
    end

    // Entry storage, written in program order at tail and tail+1.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_flush && w_push) begin
            r_mem[r_tail] <= i_in_a;
            if (i_in_valid_b) r_mem[w_tail_p1] <= i_in_b;
        end
    end

    // Absent slots read as zero so downstream sees execute=0 (a bubble).
    always_comb begin
        o_cur_a = '0;
        o_cur_b = '0;
        if (r_count >= CW'(1)) o_cur_a = r_mem[r_head];
        if (r_count >= CW'(2)) o_cur_b = r_mem[w_head_p1];
    end

    assign o_count = r_count;

    core_dispatch_queue_mask u_mask_a (
        .i_insn    (o_cur_a),
        .o_mask_ra (o_mask_a_ra),
        .o_mask_rb (o_mask_a_rb)
    );

    core_dispatch_queue_mask u_mask_b (
        .i_insn    (o_cur_b),
        .o_mask_ra (o_mask_b_ra),
        .o_mask_rb (o_mask_b_rb)
    );

    // Hazard logic must never dispatch the second slot without the first.
    a_disp_b_needs_a: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        !(i_dispatch_b && !i_dispatch_a));

    // Bubbles carry execute=0, so a pop can never exceed occupancy.
    a_pop_le_count: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        (CW'(w_n_pop) <= r_count));

endmodule

// File: doc/core_dispatch_queue.md
Name: core_dispatch_queue

Overview:
Dual-entry-per-cycle FIFO between decode and the dispatch hazard check. Buffers decoded instructions (insn_decode) in program order. Presents the two oldest as cur_a/cur_b together with their one-hot source-register masks. Retires 0, 1 or 2 entries per cycle according to the dispatch_a/dispatch_b decisions returned by the hazard logic.

Parameters:
DEPTH, 8, number of queue entries; power of two, ≥ 4.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all entries (branch redirect / exception)
in_valid_a  in  1  in_a carries a decoded instruction
in_valid_b  in  1  in_b carries a decoded instruction; only legal with in_valid_a
in_a  in  insn_decode  older incoming instruction
in_b  in  insn_decode  younger incoming instruction
in_ready  out  1  queue can accept two entries this cycle
dispatch_a  in  1  oldest entry dispatched this cycle
dispatch_b  in  1  second-oldest entry dispatched this cycle; implies dispatch_a
cur_a  out  insn_decode  oldest entry; all-zero when absent
cur_b  out  insn_decode  second-oldest entry; all-zero when absent
mask_a_ra  out  hword  one-hot of cur_a.data.ra if uses_ra, else 0
mask_a_rb  out  hword  one-hot of cur_a.data.rb if uses_rb, else 0
mask_b_ra  out  hword  same for cur_b ra
mask_b_rb  out  hword  same for cur_b rb
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH insn_decode entries. head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is one bit wider.
- Reset: head = tail = count = 0. in_ready = 1. cur_a, cur_b and all masks read 0.
- Read side is combinational from head:
  - cur_a = entry[head] if count ≥ 1, else '0.
  - cur_b = entry[head+1 mod DEPTH] if count ≥ 2, else '0.
  - An absent slot therefore has ctrl.execute = 0, which lets hazards treat it as a bubble.
- Masks: derived combinationally from cur_a/cur_b. A zeroed slot yields zero masks.
- in_ready = (DEPTH − count ≥ 2), computed from registered count only. Pops in the same cycle do not raise in_ready (no bypass).
- Push, at rising edge when in_ready and in_valid_a:
  - in_a is written at tail.
  - If in_valid_b, in_b is written at tail+1.
  - tail advances by 1 or 2.
  - Inputs presented while in_ready = 0 are ignored; the producer holds them.
- Pop at rising edge: n_pop = dispatch_a + (dispatch_a & dispatch_b). head advances by n_pop.
  - dispatch_b without dispatch_a is illegal (assertion) and treated as no pop.
  - A pop is never larger than count. dispatch on a zero slot cannot occur because execute = 0 there; assert it anyway.
- Push and pop in the same cycle: count_next = count + n_push − n_pop. When the queue is empty, a pushed entry appears on cur_a the cycle after the push (1-cycle latency, no write-through).
- Wrap-around: writes at tail = DEPTH−1 with 2 entries land at DEPTH−1 and 0. cur_b at head = DEPTH−1 reads entry 0.
- flush: at the edge, head = tail = count = 0. Flush overrides any push and pop in the same cycle; nothing from in_a/in_b is retained.
- rst has priority over flush. Reset mid-operation discards all contents identically.
- Entry storage is not cleared on reset or flush; validity comes only from count.

Decomposition:
- insn_decode and hword stay in the existing core/uarch.sv package.
- Add to the package:
  - a dispatch_queue_depth constant (default 8);
  - a function reg_onehot(reg_num r, logic use) returning hword.
- Natural sub-module: core_dispatch_queue_mask, a purely combinational decoder that turns one insn_decode into its ra/rb hword masks. Instantiate it twice (slots a and b).

Test Plan:
1. Reset, then push A (ra = 3, uses_ra) and B (rb = 5, uses_rb) in one cycle → next cycle: count = 2, cur_a = A, cur_b = B, mask_a_ra = 16'h0008, mask_b_rb = 16'h0020, mask_a_rb = 0.
2. Fill to 7 entries → in_ready = 0. Push attempt with in_valid_a is ignored; count stays 7. Dispatch_a=1 gives count 6 and in_ready = 1 the following cycle, not the same cycle.
3. head = 7 with 2 entries, dispatch_a = dispatch_b = 1, while pushing 2 → head = 1, count = 2, order preserved across the wrap.
4. count = 3, dispatch_a=1 and dispatch_b=0, push 1 → count = 3. The old cur_b becomes the new cur_a.
5. count = 5, flush asserted with push and pop → count = 0, cur_a.ctrl.execute = 0, all masks 0. The next push appears on cur_a one cycle later.
6. Assert rst mid-stream with count = 4 → next cycle count = 0, in_ready = 1, outputs zero. An injected dispatch_b without dispatch_a fires the assertion and count is unchanged.
